linked_list_fifo_arbiter: RTL and testbench

//  Sequences access to the shared linked_list_fifo from NUM_FIFOS requesters.

---
 rtl/linked_list_fifo_arbiter_if.sv | 24 ++
 rtl/linked_list_fifo_arbiter.sv | 112 +++++++++++
 tb/tb_linked_list_fifo_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/linked_list_fifo_arbiter_if.sv
// rtl/linked_list_fifo_arbiter_if.sv - request/grant and fifo flag bundle for linked_list_fifo_arbiter
interface linked_list_fifo_arbiter_if #(
    parameter int NUM_FIFOS = 2,
    parameter int CNT_WIDTH = 3
);
    logic [NUM_FIFOS-1:0] push_req;
    logic [NUM_FIFOS-1:0] pop_req;
    logic                 fifo_full;
    logic [NUM_FIFOS-1:0] fifo_empty;
    logic [NUM_FIFOS-1:0] push;
    logic [NUM_FIFOS-1:0] pop;
    logic [CNT_WIDTH-1:0] total_count;
    logic                 occ_err;

    modport master (
        output push_req, pop_req, fifo_full, fifo_empty,
        input  push, pop, total_count, occ_err
    );

    modport slave (
        input  push_req, pop_req, fifo_full, fifo_empty,
        output push, pop, total_count, occ_err
    );
endinterface

// File: rtl/linked_list_fifo_arbiter.sv
// rtl/linked_list_fifo_arbiter.sv - round-robin push/pop arbiter with per-queue quota for a shared linked-list fifo
module linked_list_fifo_arbiter #(
    parameter int DEPTH     = 4,
    parameter int NUM_FIFOS = 2,
    parameter int QUOTA     = DEPTH,
    parameter int IDX_WIDTH = $clog2(NUM_FIFOS),
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    linked_list_fifo_arbiter_if.slave    bus
);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] QUOTA_C = CNT_WIDTH'(QUOTA);
    localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);
    localparam logic [NUM_FIFOS-1:0] BIT0_C  = NUM_FIFOS'(1);

    logic [CNT_WIDTH-1:0] occ [NUM_FIFOS];
    logic [CNT_WIDTH-1:0] total;
    logic [IDX_WIDTH-1:0] push_ptr;
    logic [IDX_WIDTH-1:0] pop_ptr;
    logic                 occ_err_q;

    logic [NUM_FIFOS-1:0] push_elig;
    logic [NUM_FIFOS-1:0] pop_elig;
    logic                 push_hit;
    logic                 pop_hit;
    logic [IDX_WIDTH-1:0] push_idx;
    logic [IDX_WIDTH-1:0] pop_idx;
    logic [NUM_FIFOS-1:0] push_gnt;
    logic [NUM_FIFOS-1:0] pop_gnt;
    logic                 flag_mismatch;

    // Modulo add done in int so a non-power-of-2 NUM_FIFOS wraps at NUM_FIFOS, not 2**IDX_WIDTH.
    function automatic logic [IDX_WIDTH-1:0] wrap_add(input logic [IDX_WIDTH-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_FIFOS) s = s - NUM_FIFOS;
        return IDX_WIDTH'(s);
    endfunction

    always_comb begin
        push_elig     = '0;
        pop_elig      = '0;
        flag_mismatch = (bus.fifo_full != (total == DEPTH_C));
        for (int i = 0; i < NUM_FIFOS; i++) begin
            push_elig[i] = bus.push_req[i] & ~bus.fifo_full & (total < DEPTH_C) & (occ[i] < QUOTA_C);
            pop_elig[i]  = bus.pop_req[i] & (occ[i] != '0);
            if ((occ[i] == '0) != bus.fifo_empty[i]) flag_mismatch = 1'b1;
        end
    end

    always_comb begin
        push_hit = 1'b0;
        push_idx = push_ptr;
        pop_hit  = 1'b0;
        pop_idx  = pop_ptr;
        for (int k = 0; k < NUM_FIFOS; k++) begin
            if (!push_hit && push_elig[wrap_add(push_ptr, k)]) begin
                push_hit = 1'b1;
                push_idx = wrap_add(push_ptr, k);
            end
            if (!pop_hit && pop_elig[wrap_add(pop_ptr, k)]) begin
                pop_hit = 1'b1;
                pop_idx = wrap_add(pop_ptr, k);
            end
        end
    end

    // Grants are suppressed throughout reset so the fifo never sees a control while it is being cleared.
    assign push_gnt = (rst && push_hit) ? (BIT0_C << push_idx) : '0;
    assign pop_gnt  = (rst && pop_hit)  ? (BIT0_C << pop_idx)  : '0;

    assign bus.push        = push_gnt;
    assign bus.pop         = pop_gnt;
    assign bus.total_count = total;
    assign bus.occ_err     = occ_err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_FIFOS; i++) occ[i] <= '0;
            total     <= '0;
            push_ptr  <= '0;
            pop_ptr   <= '0;
            occ_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                if (push_gnt[i] && !pop_gnt[i])      occ[i] <= occ[i] + ONE_C;
                else if (pop_gnt[i] && !push_gnt[i]) occ[i] <= occ[i] - ONE_C;
            end
            if ((|push_gnt) && !(|pop_gnt))      total <= total + ONE_C;
            else if ((|pop_gnt) && !(|push_gnt)) total <= total - ONE_C;
            if (push_hit) push_ptr <= wrap_add(push_idx, 1);
            if (pop_hit)  pop_ptr  <= wrap_add(pop_idx, 1);
            if (flag_mismatch) occ_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert ($onehot0(push_gnt));
            assert ($onehot0(pop_gnt));
            assert (!((|push_gnt) && bus.fifo_full));
            assert (!((|push_gnt) && !(|pop_gnt) && total == DEPTH_C));
            assert (!((|pop_gnt) && !(|push_gnt) && total == '0));
            for (int i = 0; i < NUM_FIFOS; i++) begin
                assert (!(pop_gnt[i] && bus.fifo_empty[i]));
                assert (!(push_gnt[i] && !pop_gnt[i] && occ[i] == DEPTH_C));
            end
        end
    end
endmodule

// File: tb/tb_linked_list_fifo_arbiter.sv
// tb/tb_linked_list_fifo_arbiter.sv - scoreboard bench for linked_list_fifo_arbiter (DEPTH=4, NUM_FIFOS=2, QUOTA=3)
module tb_linked_list_fifo_arbiter;
    localparam int NF = 2;
    localparam int D  = 4;
    localparam int Q  = 3;
    localparam int CW = $clog2(D + 1);

    typedef struct {
        int         id;
        logic [1:0] push;
        logic [1:0] pop;
        int         total;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   vec_id = 0;

    always #5 clk = ~clk;

    linked_list_fifo_arbiter_if #(.NUM_FIFOS(NF), .CNT_WIDTH(CW)) bus ();

    linked_list_fifo_arbiter #(.DEPTH(D), .NUM_FIFOS(NF), .QUOTA(Q)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input int id, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL v%0d %s: got %0d expected %0d", id, name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus just after the edge and queue what the DUT must show in that cycle.
    task automatic step(input logic r, input logic [1:0] preq, input logic [1:0] qreq,
                        input logic full, input logic [1:0] empty,
                        input logic [1:0] ep, input logic [1:0] eq, input int et, input logic ee);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = r;
        bus.push_req   = preq;
        bus.pop_req    = qreq;
        bus.fifo_full  = full;
        bus.fifo_empty = empty;
        e.id    = vec_id;
        e.push  = ep;
        e.pop   = eq;
        e.total = et;
        e.err   = ee;
        exp_q.push_back(e);
        vec_id++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("push",  e.id, (^bus.push === 1'bx) ? -1 : int'(bus.push), int'(e.push));
            check("pop",   e.id, (^bus.pop === 1'bx) ? -1 : int'(bus.pop), int'(e.pop));
            check("total", e.id, (^bus.total_count === 1'bx) ? -1 : int'(bus.total_count), e.total);
            check("occ_err", e.id, (bus.occ_err === 1'bx) ? -1 : int'(bus.occ_err), int'(e.err));
        end
    end

    initial begin
        rst            = 1'b0;
        bus.push_req   = 2'b11;
        bus.pop_req    = 2'b11;
        bus.fifo_full  = 1'b0;
        bus.fifo_empty = 2'b11;

        // reset held with all requests active
        step(0, 2'b11, 2'b11, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        step(0, 2'b11, 2'b11, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        step(0, 2'b11, 2'b11, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        // round-robin push fill, then full
        step(1, 2'b11, 2'b00, 0, 2'b11, 2'b01, 2'b00, 0, 0);
        step(1, 2'b11, 2'b00, 0, 2'b10, 2'b10, 2'b00, 1, 0);
        step(1, 2'b11, 2'b00, 0, 2'b00, 2'b01, 2'b00, 2, 0);
        step(1, 2'b11, 2'b00, 0, 2'b00, 2'b10, 2'b00, 3, 0);
        step(1, 2'b11, 2'b00, 1, 2'b00, 2'b00, 2'b00, 4, 0);
        // reset mid-operation: total still shows 4 until the edge
        step(0, 2'b00, 2'b00, 0, 2'b11, 2'b00, 2'b00, 4, 0);
        // quota of 3 on queue 0
        step(1, 2'b01, 2'b00, 0, 2'b11, 2'b01, 2'b00, 0, 0);
        step(1, 2'b01, 2'b00, 0, 2'b10, 2'b01, 2'b00, 1, 0);
        step(1, 2'b01, 2'b00, 0, 2'b10, 2'b01, 2'b00, 2, 0);
        step(1, 2'b01, 2'b00, 0, 2'b10, 2'b00, 2'b00, 3, 0);
        step(1, 2'b01, 2'b00, 0, 2'b10, 2'b00, 2'b00, 3, 0);
        step(1, 2'b10, 2'b00, 0, 2'b10, 2'b10, 2'b00, 3, 0);
        // full: pop granted, push refused in the same cycle
        step(1, 2'b01, 2'b01, 1, 2'b00, 2'b00, 2'b01, 4, 0);
        step(1, 2'b01, 2'b00, 0, 2'b00, 2'b01, 2'b00, 3, 0);
        step(1, 2'b00, 2'b10, 1, 2'b00, 2'b00, 2'b10, 4, 0);
        // empty queue 1: push granted, pop refused; then pop drains it
        step(1, 2'b10, 2'b10, 0, 2'b10, 2'b10, 2'b00, 3, 0);
        step(1, 2'b10, 2'b10, 1, 2'b00, 2'b00, 2'b10, 4, 0);
        step(1, 2'b00, 2'b10, 0, 2'b10, 2'b00, 2'b00, 3, 0);
        // bring occ[0] to 2, then present an inconsistent empty flag
        step(1, 2'b00, 2'b01, 0, 2'b10, 2'b00, 2'b01, 3, 0);
        step(1, 2'b00, 2'b00, 0, 2'b11, 2'b00, 2'b00, 2, 0);
        step(1, 2'b00, 2'b00, 0, 2'b10, 2'b00, 2'b00, 2, 1);
        step(1, 2'b00, 2'b00, 0, 2'b10, 2'b00, 2'b00, 2, 1);
        step(0, 2'b00, 2'b00, 0, 2'b11, 2'b00, 2'b00, 2, 1);
        step(1, 2'b00, 2'b00, 0, 2'b11, 2'b00, 2'b00, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
